dallan_cozum_denetleyici: RTL
=============================

# dallan_cozum_denetleyici

Branch resolution and predictor-update scheduler between the fetch stage, the gshare predictor and the execute stage. It holds every in-flight predicted conditional branch in program order and checks each execute-stage outcome against its prediction. On a mispredict it raises a one-cycle redirect/flush with global-history restore. It shares the predictor's single table port between fetch lookups and training updates, deferring updates while fetch is using the port and forcing one through with a fetch stall when deferral exceeds a bound.

## Interface
- DERINLIK, 4, in-flight branch queue entries (power of two, ≥2)
- GHR_W, 5, global history width
- STARVE_MAX, 3, consecutive denied cycles before an update is forced (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock, synchronous and active-high
- getir_dallan_gecerli_i  in  1  fetch pushes a predicted conditional branch
- getir_ps_i  in  32  branch PC
- getir_tahmin_atladi_i  in  1  predicted taken
- getir_tahmin_ps_i  in  32  predicted target (meaningful when taken)
- getir_ghr_i  in  GHR_W  history snapshot used for the prediction
- getir_sorgu_i  in  1  fetch is using the predictor port this cycle
- getir_durdur_o  out  1  fetch stall
- yurut_gecerli_i  in  1  execute resolves the oldest branch
- yurut_hazir_o  out  1  resolution accepted when high
- yurut_atladi_i  in  1  actual direction
- yurut_hedef_ps_i  in  32  actual taken target
- yurut_sonraki_ps_i  in  32  fall-through PC
- yanlis_tahmin_o  out  1  mispredict / flush pulse
- duzeltme_ps_o  out  32  redirect PC
- ghr_geri_deger_o  out  GHR_W  restored history
- guncelle_gecerli_o  out  1  predictor update strobe
- guncelle_ps_o  out  32  PC to train
- guncelle_ghr_o  out  GHR_W  snapshot to index with
- guncelle_atladi_o  out  1  outcome to train
- doluluk_o  out  $clog2(DERINLIK)+1  queue occupancy

## Operation
- Branch queue: circular FIFO of {ps, tahmin_atladi, tahmin_ps, ghr}, separate read/write pointers plus count; pointers wrap mod DERINLIK.
- Push accepted iff getir_dallan_gecerli_i and (count<DERINLIK, or a pop occurs the same cycle). A push while full with no pop is dropped.
- Resolution accepted iff yurut_gecerli_i && yurut_hazir_o && count>0. A resolution while empty is ignored and produces no output.
- yurut_hazir_o = update buffer not full.
- Mispredict iff actual≠predicted direction, or both taken and yurut_hedef_ps_i≠stored tahmin_ps.
- On mispredict: the whole branch queue clears, including a push in the same cycle. duzeltme_ps_o = taken ? hedef : sonraki. ghr_geri_deger_o = {snapshot[GHR_W-2:0], actual}.
- Every accepted resolution, correct or not, writes {ps, ghr, actual} into a 2-entry update FIFO. A mispredict never clears the update FIFO.
- Port arbitration: grant = !getir_sorgu_i || zorla_q. guncelle_gecerli_o = update FIFO nonempty && grant, and the head pops at the same edge.
- Starve counter:
  - increments each cycle the FIFO is nonempty and grant=0;
  - reaching STARVE_MAX sets zorla_q for the next cycle;
  - clears on any issued update or when the FIFO is empty;
  - zorla_q clears after one cycle.
- getir_durdur_o = (count==DERINLIK) || zorla_q.

## Timing
- Reset: queue, update FIFO, counters and zorla_q all cleared. All outputs are 0 the cycle after rst_i, except yurut_hazir_o=1. Reset mid-operation discards all pending updates and entries.
- Mispredict outputs are registered: they appear in the cycle after the accepting edge and hold 1 cycle. The queue is already empty in that cycle.
- Update latency: an update strobe can appear at the earliest one cycle after the resolution edge.
- Worst-case deferral is STARVE_MAX+1 cycles.
- guncelle_*, getir_durdur_o and yurut_hazir_o are combinational from registers and getir_sorgu_i only.
- doluluk_o reflects the post-edge count.

## Test plan
- Push PCs 0x100, 0x104, 0x108, 0x10C (not-taken), then a fifth push while full → getir_durdur_o=1, doluluk_o=4, fifth push dropped. Resolve with not-taken → no yanlis_tahmin_o, 4 updates issued in order.
- Push 0x200 predicted taken to 0x240; resolve taken with hedef 0x260 → next cycle yanlis_tahmin_o=1, duzeltme_ps_o=0x260, doluluk_o=0.
- getir_ghr_i=5'b10110 predicted not-taken, resolved taken with sonraki 0x304 → duzeltme_ps_o=hedef, ghr_geri_deger_o=5'b01101. A same-cycle push is discarded.
- Hold getir_sorgu_i=1 with one pending update, STARVE_MAX=3 → strobe absent for 3 cycles, then getir_durdur_o=1 and guncelle_gecerli_o=1 together in cycle 4.
- Three back-to-back resolutions while getir_sorgu_i=1 → yurut_hazir_o drops after two; the third resolution is held until the first forced update.
- Assert rst_i with 3 entries queued and 1 update pending → next cycle all outputs 0, yurut_hazir_o=1, no update strobe afterwards.

Source files
------------

// File: rtl/dallan_cozum_denetleyici.sv
// Branch resolution and predictor-update scheduler: in-order branch queue,
// mispredict redirect with history restore, and predictor port arbitration.
module dallan_cozum_denetleyici #(
    parameter int DERINLIK   = 4,
    parameter int GHR_W      = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        getir_dallan_gecerli_i,
    input  logic [31:0]                 getir_ps_i,
    input  logic                        getir_tahmin_atladi_i,
    input  logic [31:0]                 getir_tahmin_ps_i,
    input  logic [GHR_W-1:0]            getir_ghr_i,
    input  logic                        getir_sorgu_i,
    output logic                        getir_durdur_o,
    input  logic                        yurut_gecerli_i,
    output logic                        yurut_hazir_o,
    input  logic                        yurut_atladi_i,
    input  logic [31:0]                 yurut_hedef_ps_i,
    input  logic [31:0]                 yurut_sonraki_ps_i,
    output logic                        yanlis_tahmin_o,
    output logic [31:0]                 duzeltme_ps_o,
    output logic [GHR_W-1:0]            ghr_geri_deger_o,
    output logic                        guncelle_gecerli_o,
    output logic [31:0]                 guncelle_ps_o,
    output logic [GHR_W-1:0]            guncelle_ghr_o,
    output logic                        guncelle_atladi_o,
    output logic [$clog2(DERINLIK):0]   doluluk_o
);
    localparam int PW = $clog2(DERINLIK);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Branch queue storage
    logic [31:0]      q_ps     [DERINLIK];
    logic             q_tat    [DERINLIK];
    logic [31:0]      q_tps    [DERINLIK];
    logic [GHR_W-1:0] q_ghr    [DERINLIK];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Two-entry update FIFO
    logic [31:0]      u_ps     [2];
    logic [GHR_W-1:0] u_ghr    [2];
    logic             u_at     [2];
    logic             u_wr_reg, u_rd_reg;
    logic [1:0]       u_cnt_reg;

    logic [SW-1:0]    starve_reg;
    logic             zorla_reg;

    logic             yanlis_reg;
    logic [31:0]      duzeltme_reg;
    logic [GHR_W-1:0] ghr_geri_reg;

    logic             full, cozum_kabul, push_ok, yanlis_next, grant, u_bos;
    logic             tah_at;
    logic [31:0]      tah_ps;
    logic [GHR_W-1:0] tah_ghr;

    assign full        = (count_reg == CW'(DERINLIK));
    assign tah_at      = q_tat[rd_ptr_reg];
    assign tah_ps      = q_tps[rd_ptr_reg];
    assign tah_ghr     = q_ghr[rd_ptr_reg];
    assign u_bos       = (u_cnt_reg == 2'd0);
    assign grant       = !getir_sorgu_i || zorla_reg;

    assign yurut_hazir_o      = (u_cnt_reg != 2'd2);
    assign cozum_kabul        = yurut_gecerli_i && yurut_hazir_o && (count_reg != '0);
    assign push_ok            = getir_dallan_gecerli_i && (!full || cozum_kabul);
    assign yanlis_next        = cozum_kabul &&
                                ((yurut_atladi_i != tah_at) ||
                                 (yurut_atladi_i && tah_at && (yurut_hedef_ps_i != tah_ps)));

    assign guncelle_gecerli_o = !u_bos && grant;
    assign guncelle_ps_o      = guncelle_gecerli_o ? u_ps[u_rd_reg]  : '0;
    assign guncelle_ghr_o     = guncelle_gecerli_o ? u_ghr[u_rd_reg] : '0;
    assign guncelle_atladi_o  = guncelle_gecerli_o ? u_at[u_rd_reg]  : 1'b0;
    assign getir_durdur_o     = full || zorla_reg;
    assign doluluk_o          = count_reg;
    assign yanlis_tahmin_o    = yanlis_reg;
    assign duzeltme_ps_o      = duzeltme_reg;
    assign ghr_geri_deger_o   = ghr_geri_reg;

    // Per-entry queue write; contents need no reset since count gates them.
    for (genvar gi = 0; gi < DERINLIK; gi++) begin : g_kuyruk
        always_ff @(posedge clk_i) begin
            if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                q_ps[gi]  <= getir_ps_i;
                q_tat[gi] <= getir_tahmin_atladi_i;
                q_tps[gi] <= getir_tahmin_ps_i;
                q_ghr[gi] <= getir_ghr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cozum_kabul) begin
            u_ps[u_wr_reg]  <= q_ps[rd_ptr_reg];
            u_ghr[u_wr_reg] <= tah_ghr;
            u_at[u_wr_reg]  <= yurut_atladi_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            u_wr_reg     <= 1'b0;
            u_rd_reg     <= 1'b0;
            u_cnt_reg    <= 2'd0;
            starve_reg   <= '0;
            zorla_reg    <= 1'b0;
            yanlis_reg   <= 1'b0;
            duzeltme_reg <= '0;
            ghr_geri_reg <= '0;
        end else begin
            // A mispredict flushes everything younger, including this cycle's push.
            if (yanlis_next) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (cozum_kabul)
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                count_reg <= count_reg + CW'(push_ok) - CW'(cozum_kabul);
            end

            if (cozum_kabul)
                u_wr_reg <= ~u_wr_reg;
            if (guncelle_gecerli_o)
                u_rd_reg <= ~u_rd_reg;
            u_cnt_reg <= u_cnt_reg + 2'(cozum_kabul) - 2'(guncelle_gecerli_o);

            if (u_bos || guncelle_gecerli_o) begin
                starve_reg <= '0;
                zorla_reg  <= 1'b0;
            end else if (starve_reg == SW'(STARVE_MAX - 1)) begin
                starve_reg <= '0;
                zorla_reg  <= 1'b1;
            end else begin
                starve_reg <= starve_reg + SW'(1);
                zorla_reg  <= 1'b0;
            end

            yanlis_reg   <= yanlis_next;
            duzeltme_reg <= yanlis_next ? (yurut_atladi_i ? yurut_hedef_ps_i : yurut_sonraki_ps_i) : '0;
            ghr_geri_reg <= yanlis_next ? {tah_ghr[GHR_W-2:0], yurut_atladi_i} : '0;
        end
    end
endmodule
